// File: rtl/bcd_cnt2_scan_mod.sv
// Two-digit BCD up/down counter with count-rate prescaler,
// parallel load and a two-digit multiplexed display scanner.
module bcd_cnt2_scan_mod #(
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       carry,
  output logic       load_err,
  output logic [3:0] bcd_out,
  output logic [1:0] digit_com
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_scan_cnt;
  logic          r_sel;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_carry;
  logic          r_load_err;

  logic          w_tick;
  logic          w_ld_ok;
  logic          w_ld_bad;
  logic [3:0]    w_nx_tens;
  logic [3:0]    w_nx_ones;
  logic          w_wrap;

  assign w_tick   = run && (r_tick_cnt == TMAX);
  assign w_ld_ok  = load && (load_val[7:4] <= 4'd9)
                         && (load_val[3:0] <= 4'd9);
  assign w_ld_bad = load && !w_ld_ok;

  // Next BCD value for one count step in the selected direction
  always_comb begin
    w_nx_tens = r_tens;
    w_nx_ones = r_ones;
    w_wrap    = 1'b0;
    if (up_dn) begin
      if (r_ones != 4'd9) begin
        w_nx_ones = r_ones + 4'd1;
      end else begin
        w_nx_ones = 4'd0;
        if (r_tens != 4'd9) begin
          w_nx_tens = r_tens + 4'd1;
        end else begin
          w_nx_tens = 4'd0;
          w_wrap    = 1'b1;
        end
      end
    end else begin
      if (r_ones != 4'd0) begin
        w_nx_ones = r_ones - 4'd1;
      end else begin
        w_nx_ones = 4'd9;
        if (r_tens != 4'd0) begin
          w_nx_tens = r_tens - 4'd1;
        end else begin
          w_nx_tens = 4'd9;
          w_wrap    = 1'b1;
        end
      end
    end
  end

  // Prescaler: advances only with run; a good load restarts
  // the period, a bad load freezes it for that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_ld_ok) begin
      r_tick_cnt <= '0;
    end else if (!w_ld_bad && run) begin
      if (w_tick) r_tick_cnt <= '0;
      else        r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Count register with load priority over tick, plus pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_load_err <= w_ld_bad;
      if (w_ld_ok) begin
        r_tens <= load_val[7:4];
        r_ones <= load_val[3:0];
      end else if (!load && w_tick) begin
        r_tens  <= w_nx_tens;
        r_ones  <= w_nx_ones;
        r_carry <= w_wrap;
      end
    end
  end

  // Free-running scan divider; digit select flips on each wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_sel      <= 1'b0;
    end else if (r_scan_cnt == SMAX) begin
      r_scan_cnt <= '0;
      r_sel      <= ~r_sel;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign bcd_tens  = r_tens;
  assign bcd_ones  = r_ones;
  assign carry     = r_carry;
  assign load_err  = r_load_err;
  assign bcd_out   = r_sel ? r_tens : r_ones;
  assign digit_com = r_sel ? 2'b01 : 2'b10;

endmodule

// File: doc/bcd_cnt2_scan_mod.md
# bcd_cnt2_scan_mod

Two-digit BCD up/down counter (00–99) with a count-rate prescaler and a two-digit display scanner. It sits directly upstream of the BCD-to-7-segment decoder in the two-digit display path. `bcd_out` drives the decoder's BCD input, and `digit_com` selects which common of the two-digit display is lit. A parallel load and a wrap (carry/borrow) pulse let it chain with control logic.

## Interface
- TICK_DIV, 1000, clock cycles per count step while `run`=1; legal range ≥1.
- SCAN_DIV, 100, clock cycles each digit stays selected; legal range ≥1.

- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  level; 1 = prescaler advances and counting enabled.
- up_dn  in  1  1 = count up, 0 = count down; sampled at each tick.
- load  in  1  synchronous load strobe, sampled on `clk`.
- load_val  in  8  {tens[7:4], ones[3:0]} BCD value to load.
- bcd_tens  out  4  registered tens digit, 0–9.
- bcd_ones  out  4  registered ones digit, 0–9.
- carry  out  1  one-cycle pulse on wrap 99→00 (up) or 00→99 (down).
- load_err  out  1  one-cycle pulse when `load` is presented with a nibble >9.
- bcd_out  out  4  digit currently scanned; feeds the decoder.
- digit_com  out  2  active-low digit select: bit0 = ones, bit1 = tens.

## Operation
**Reset (async, `rst`=1).** Every output and internal register returns to reset immediately, independent of `clk`:
- tick_cnt=0, scan_cnt=0, sel=0.
- `bcd_tens`=0, `bcd_ones`=0.
- `carry`=0, `load_err`=0.
- `bcd_out`=0, `digit_com`=2'b10.

**Prescaler.**
- tick_cnt counts 0..TICK_DIV-1 only while `run`=1, holds while `run`=0.
- tick = `run` && tick_cnt==TICK_DIV-1; tick_cnt wraps to 0 on that edge.
- TICK_DIV=1 means a tick every cycle while `run`=1.

**Count step on tick, up (`up_dn`=1).**
- ones<9: ones+1.
- ones=9: ones=0 and tens+1.
- 99 → 00 and `carry`=1.

**Count step on tick, down (`up_dn`=0).**
- ones>0: ones-1.
- ones=0: ones=9 and tens-1.
- 00 → 99 and `carry`=1.

**Load priority.** Load has priority over tick.
- `load`=1 with both nibbles ≤9: count ← `load_val`, tick_cnt ← 0, no `carry` that cycle even if a tick coincided.
- `load`=1 with either nibble >9: count and tick_cnt unchanged, `load_err`=1 for one cycle. A coincident tick is still suppressed.

**Scanner.**
- scan_cnt is free-running, independent of `run` and `load`. It counts 0..SCAN_DIV-1, and on wrap sel toggles.
- sel=0: `bcd_out`=`bcd_ones`, `digit_com`=2'b10.
- sel=1: `bcd_out`=`bcd_tens`, `digit_com`=2'b01.
- Exactly one `digit_com` bit is low at all times. Never 2'b00 or 2'b11.
- `bcd_out` is a combinational mux of registered sel and registered count. A count change is therefore visible on `bcd_out` in the same cycle it appears on `bcd_tens`/`bcd_ones` (if that digit is selected).

**Invariant.** `bcd_tens` and `bcd_ones` are never >9.

## Timing
- Count latency: with `run` held at 1 from tick_cnt=0, the count changes on the TICK_DIV-th rising edge, and then every TICK_DIV edges.
- `run` deasserted mid-period: tick_cnt freezes. On reassertion, counting resumes from the frozen value (the partial period is not lost).
- `carry` is high exactly in the cycle the wrapped value is first present on the outputs. It drops the next cycle.
- Load: the new value is present after the edge on which `load`=1. The next tick comes TICK_DIV `run`-cycles later.
- `load_err` is high the cycle after the edge sampling the bad load, for one cycle. If `load` is held across N edges, the response repeats N times.
- `up_dn` change: takes effect at the next tick. There is no partial step.
- Scan: sel toggles every SCAN_DIV edges after reset release, giving a full refresh period of 2·SCAN_DIV.
- `rst` asserted mid-count or mid-scan: outputs reach reset values without waiting for `clk`. After release, counting restarts from tick_cnt=0.

## Test plan
- Reset, TICK_DIV=4, `run`=1, `up_dn`=1 for 400 cycles -> count reaches 99 at cycle 396. At cycle 400 it shows 00 with `carry`=1 for exactly one cycle; no other `carry` pulses.
- Load 8'h00, `up_dn`=0, one tick -> count 99, `carry`=1. Next tick -> 98, `carry`=0. From 8'h40, one down tick -> 39.
- `load_val`=8'h5A, then 8'hA5, with `load`=1 -> `load_err` pulses each time, count unchanged. `load_val`=8'h57 -> count 57, `load_err`=0.
- `load` coincident with a tick at count 99 up, `load_val`=8'h12 -> count 12, `carry`=0, next change 13 after TICK_DIV cycles.
- SCAN_DIV=3, count 47 -> `digit_com`/`bcd_out` alternate 2'b10/7 and 2'b01/4 every 3 cycles. `digit_com` is never 2'b00 or 2'b11.
- `rst` pulsed between clock edges mid-count at 63 -> outputs are 00, `digit_com`=2'b10, `carry`=0 before the next edge. `run` low for 10 cycles freezes the count.
